// File: rtl/spi_slave_param_if.sv
// Bus bundle between the SPI slave front-end and its environment (SPI pins plus RAM side).
// Optional frame_err signal exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned FRAME_W = DATA_W + 2;

  logic               MOSI;
  logic               ss_n;
  logic               tx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               MISO;
  logic               rx_valid;
  logic [FRAME_W-1:0] rx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic               frame_err;
`endif

  modport slave (
    input  MOSI, ss_n, tx_valid, tx_data,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output frame_err,
`endif
    output MISO, rx_valid, rx_data
  );

  modport master (
    output MOSI, ss_n, tx_valid, tx_data,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    input  frame_err,
`endif
    input  MISO, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end feeding a single-port RAM.
// Captures {cmd[1:0], payload} frames from MOSI, returns RAM read data on MISO.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds the frame_err abort pulse.
module spi_slave_param #(
  parameter int unsigned DATA_W           = 8,
  parameter bit          ENFORCE_RD_ORDER = 1'b1,
  parameter int unsigned TX_WAIT_MAX      = 0
) (
  input logic              clk,
  input logic              rst,
  spi_slave_param_if.slave bus
);
  localparam int unsigned FRAME_W  = DATA_W + 2;
  localparam int unsigned CntW     = $clog2(FRAME_W + 1);
  localparam int unsigned TxCntW   = $clog2(DATA_W + 1);
  localparam int unsigned WaitW    = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;
  localparam int unsigned WaitLast = (TX_WAIT_MAX > 0) ? TX_WAIT_MAX - 1 : 0;

  localparam logic [CntW-1:0]   FrameLen = CntW'(FRAME_W);
  localparam logic [TxCntW-1:0] TxLast   = TxCntW'(DATA_W - 1);
  localparam logic [WaitW-1:0]  WaitEnd  = WaitW'(WaitLast);

  // READ_DATA is split into its RX / TX_WAIT / TX_SHIFT phases; DONE is shared by all
  // completed frames and simply waits for ss_n to rise.
  typedef enum logic [2:0] {
    StIdle, StChkCmd, StWrite, StReadAdd, StRdRx, StTxWait, StTxShift, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               rd_addr_ok_q, rd_addr_ok_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
  logic [TxCntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               abort_err;

  // Next-state and output logic; an ss_n abort overrides whatever the state decided.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    miso_d       = 1'b0;
    rd_addr_ok_d = rd_addr_ok_q;
    tx_sr_d      = tx_sr_q;
    tx_cnt_d     = tx_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    abort_err    = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d      = '0;
        sr_d       = '0;
        tx_cnt_d   = '0;
        wait_cnt_d = '0;
        if (!bus.ss_n) state_d = StChkCmd;
      end

      StChkCmd: begin
        if (!bus.ss_n) begin
          sr_d  = {sr_q[FRAME_W-2:0], bus.MOSI};
          cnt_d = cnt_q + CntW'(1);
          if (!bus.MOSI) begin
            state_d = StWrite;
          end else if (ENFORCE_RD_ORDER && rd_addr_ok_q) begin
            state_d = StRdRx;
          end else begin
            state_d = StReadAdd;
          end
        end
      end

      StWrite, StReadAdd, StRdRx: begin
        if (cnt_q == FrameLen) begin
          // Frame complete: deliver even if ss_n rose on this edge.
          rx_data_d  = sr_q;
          rx_valid_d = 1'b1;
          if (state_q == StReadAdd) begin
            rd_addr_ok_d = 1'b1;
            state_d      = StDone;
          end else if (state_q == StRdRx) begin
            rd_addr_ok_d = 1'b0;
            wait_cnt_d   = '0;
            state_d      = StTxWait;
          end else begin
            state_d = StDone;
          end
        end else if (!bus.ss_n) begin
          sr_d  = {sr_q[FRAME_W-2:0], bus.MOSI};
          cnt_d = cnt_q + CntW'(1);
          // Unenforced ordering: second command bit picks READ_DATA.
          if (!ENFORCE_RD_ORDER && state_q == StReadAdd && cnt_q == CntW'(1) && bus.MOSI) begin
            state_d = StRdRx;
          end
        end else begin
          abort_err = (cnt_q != '0);
        end
      end

      StTxWait: begin
        if (bus.ss_n) begin
          abort_err = 1'b1;
        end else if (bus.tx_valid) begin
          tx_sr_d  = bus.tx_data;
          tx_cnt_d = '0;
          state_d  = StTxShift;
        end else if (TX_WAIT_MAX > 0) begin
          if (wait_cnt_q == WaitEnd) begin
            state_d = StDone;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
      end

      StTxShift: begin
        if (bus.ss_n) begin
          abort_err = 1'b1;
        end else begin
          miso_d   = tx_sr_q[DATA_W-1];
          tx_sr_d  = {tx_sr_q[DATA_W-2:0], 1'b0};
          tx_cnt_d = tx_cnt_q + TxCntW'(1);
          if (tx_cnt_q == TxLast) state_d = StDone;
        end
      end

      StDone: begin
      end

      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && bus.ss_n) begin
      state_d = StIdle;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sr_q         <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      rd_addr_ok_q <= 1'b0;
      tx_sr_q      <= '0;
      tx_cnt_q     <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      tx_sr_q      <= tx_sr_d;
      tx_cnt_q     <= tx_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  assign frame_err_d = abort_err;

  // One-cycle pulse on an abort of a partial frame or a pending/active read-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  logic unused_abort_err;
  assign unused_abort_err = abort_err;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: dut_a uses the default configuration
// (ordering enforced, no tx timeout); dut_b has ordering off and TX_WAIT_MAX=4.
// Both see identical input stimulus; expectations are per instance.
module tb_spi_slave_param;
  localparam int unsigned DataW  = 8;
  localparam int unsigned FrameW = DataW + 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_param_if #(.DATA_W(DataW)) bus_a ();
  spi_slave_param_if #(.DATA_W(DataW)) bus_b ();

  spi_slave_param #(
    .DATA_W          (DataW),
    .ENFORCE_RD_ORDER(1'b1),
    .TX_WAIT_MAX     (0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  spi_slave_param #(
    .DATA_W          (DataW),
    .ENFORCE_RD_ORDER(1'b0),
    .TX_WAIT_MAX     (4)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mosi, input logic ssn, input logic txv,
                       input logic [DataW-1:0] txd);
    bus_a.MOSI = mosi;  bus_b.MOSI = mosi;
    bus_a.ss_n = ssn;   bus_b.ss_n = ssn;
    bus_a.tx_valid = txv; bus_b.tx_valid = txv;
    bus_a.tx_data = txd;  bus_b.tx_data = txd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Selects the slave (IDLE -> CHK_CMD edge), then clocks in all frame bits MSB first.
  task automatic send_bits(input logic [FrameW-1:0] f);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    for (int i = FrameW - 1; i >= 0; i--) begin
      drive(f[i], 1'b0, 1'b0, '0);
      step();
    end
  endtask

  logic [DataW-1:0] exp_c3;

  initial begin
    exp_c3 = 8'hC3;
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);
    #1;
    check_eq("rst_miso_a", bus_a.MISO, 0);
    check_eq("rst_valid_a", bus_a.rx_valid, 0);
    check_eq("rst_data_a", bus_a.rx_data, 0);
    check_eq("rst_data_b", bus_b.rx_data, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("rst_ferr_a", bus_a.frame_err, 0);
`endif
    step(); step();
    rst = 1'b0;
    step();

    // Write frame 00_1010_0101
    send_bits(10'h0A5);
    check_eq("wr_latency_a", bus_a.rx_valid, 0);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("wr_valid_a", bus_a.rx_valid, 1);
    check_eq("wr_data_a", bus_a.rx_data, 10'h0A5);
    check_eq("wr_valid_b", bus_b.rx_valid, 1);
    check_eq("wr_data_b", bus_b.rx_data, 10'h0A5);
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    check_eq("wr_pulse_a", bus_a.rx_valid, 0);
    step();
    check_eq("wr_extra_valid_a", bus_a.rx_valid, 0);
    check_eq("wr_extra_data_a", bus_a.rx_data, 10'h0A5);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();

    // Read address then read data with tx_data=C3
    send_bits(10'h207);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("rdadd_data_a", bus_a.rx_data, 10'h207);
    check_eq("rdadd_data_b", bus_b.rx_data, 10'h207);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    send_bits(10'h300);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("rddat_valid_a", bus_a.rx_valid, 1);
    check_eq("rddat_data_a", bus_a.rx_data, 10'h300);
    check_eq("rddat_data_b", bus_b.rx_data, 10'h300);
    drive(1'b0, 1'b0, 1'b1, 8'hC3);
    step();
    check_eq("tx_cap_miso_a", bus_a.MISO, 0);
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    for (int i = DataW - 1; i >= 0; i--) begin
      step();
      check_eq("tx_bit_a", bus_a.MISO, exp_c3[i]);
      check_eq("tx_bit_b", bus_b.MISO, exp_c3[i]);
    end
    step();
    check_eq("tx_end_a", bus_a.MISO, 0);
    check_eq("tx_end_b", bus_b.MISO, 0);
    step();
    check_eq("tx_done_hold_a", bus_a.MISO, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();

    // Read with no prior address: dut_a treats it as READ_ADD, dut_b reads
    send_bits(10'h355);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("ord_data_a", bus_a.rx_data, 10'h355);
    check_eq("ord_data_b", bus_b.rx_data, 10'h355);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    step();
    check_eq("ord_miso_a", bus_a.MISO, 0);
    check_eq("ord_miso_b", bus_b.MISO, 1);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    check_eq("ord_abort_miso_b", bus_b.MISO, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("ord_ferr_a", bus_a.frame_err, 0);
    check_eq("ord_ferr_b", bus_b.frame_err, 1);
    step();
    check_eq("ord_ferr_clr_b", bus_b.frame_err, 0);
`endif

    // dut_a now holds a read address, so this frame goes to READ_DATA
    send_bits(10'h301);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("ord2_data_a", bus_a.rx_data, 10'h301);
    drive(1'b0, 1'b0, 1'b1, 8'h81);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("ord2_bit7_a", bus_a.MISO, 1);
    step();
    check_eq("ord2_bit6_a", bus_a.MISO, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();

    // Abort after 5 bits
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    check_eq("abort_valid_a", bus_a.rx_valid, 0);
    check_eq("abort_valid_b", bus_b.rx_valid, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("abort_ferr_a", bus_a.frame_err, 1);
`endif
    step();
    check_eq("abort_valid2_a", bus_a.rx_valid, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("abort_ferr_once_a", bus_a.frame_err, 0);
`endif
    send_bits(10'h0F0);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("post_abort_data_a", bus_a.rx_data, 10'h0F0);
    check_eq("post_abort_valid_b", bus_b.rx_valid, 1);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();

    // Timeout on dut_b: 4 idle cycles in TX_WAIT, then late tx_valid ignored
    send_bits(10'h3AA);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("to_data_b", bus_b.rx_data, 10'h3AA);
    repeat (4) step();
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < FrameW; i++) begin
      step();
      check_eq("to_late_miso_b", bus_b.MISO, 0);
      check_eq("to_miso_a", bus_a.MISO, 0);
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("to_ferr_b", bus_b.frame_err, 0);
`endif

    // Three idle cycles is still inside the window
    send_bits(10'h3AA);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b1, 8'h80);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("nto_bit7_a", bus_a.MISO, 1);
    check_eq("nto_bit7_b", bus_b.MISO, 1);
    step();
    check_eq("nto_bit6_b", bus_b.MISO, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();

    // ss_n rising right after the last bit: frame still delivered
    send_bits(10'h0C3);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    check_eq("sim_valid_a", bus_a.rx_valid, 1);
    check_eq("sim_data_a", bus_a.rx_data, 10'h0C3);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("sim_ferr_a", bus_a.frame_err, 0);
`endif
    step();
    check_eq("sim_valid2_a", bus_a.rx_valid, 0);

    // ss_n beats tx_valid in TX_WAIT (dut_b)
    send_bits(10'h3C0);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    drive(1'b0, 1'b1, 1'b1, 8'hFF);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("ssn_wins_miso_b", bus_b.MISO, 0);
    step();
    check_eq("ssn_wins_miso2_b", bus_b.MISO, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();

    // Asynchronous reset during TX_SHIFT
    send_bits(10'h3FF);
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    check_eq("pre_rst_miso_a", bus_a.MISO, 1);
    check_eq("pre_rst_miso_b", bus_b.MISO, 1);
    check_eq("pre_rst_data_b", bus_b.rx_data, 10'h3FF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_miso_a", bus_a.MISO, 0);
    check_eq("arst_miso_b", bus_b.MISO, 0);
    check_eq("arst_valid_b", bus_b.rx_valid, 0);
    check_eq("arst_data_b", bus_b.rx_data, 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    rst = 1'b0;
    step();
    check_eq("post_rst_miso_b", bus_b.MISO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
